ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_if.sv | 37 +++
 rtl/ram_port_arbiter.sv | 118 +++++++++++
 tb/tb_ram_port_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - CPU/DMA request, response and RAM port-a signals of ram_port_arbiter
interface ram_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [7:0]  rdata;
  logic [15:0] ram_address_a;
  logic [7:0]  ram_data_a;
  logic        ram_wren_a;
  logic [7:0]  ram_q_a;

  // slave: the arbiter; master: requesters plus the RAM behind port a
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ram_q_a,
    output cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
    output ram_address_a, ram_data_a, ram_wren_a
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ram_q_a,
    input  cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, rdata,
    input  ram_address_a, ram_data_a, ram_wren_a
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - CPU-priority RAM port-a arbiter with DMA anti-starvation slot
// Optional grant/conflict statistics counters enabled by macro RAM_ARB_STATS_EN.
module ram_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   bus,
  output logic [15:0]         cpu_grant_count,
  output logic [15:0]         dma_grant_count,
  output logic [15:0]         conflict_count
);

  typedef enum logic {
    PRIO  = 1'b0,
    FORCE = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        cpu_rvalid_q, dma_rvalid_q;
  logic        cpu_rvalid_d, dma_rvalid_d;
  logic        cpu_win, dma_win, prio_conflict;

  // Grants are gated by reset so nothing reaches the RAM while reset is held.
  always_comb begin
    cpu_win       = 1'b0;
    dma_win       = 1'b0;
    prio_conflict = 1'b0;
    if (reset) begin
      if (state_q == FORCE) begin
        dma_win = bus.dma_req;
        cpu_win = bus.cpu_req & ~bus.dma_req;
      end else begin
        cpu_win       = bus.cpu_req;
        dma_win       = bus.dma_req & ~bus.cpu_req;
        prio_conflict = bus.cpu_req & bus.dma_req;
      end
    end
  end

  always_comb begin
    state_d    = PRIO;
    wait_cnt_d = 4'd0;
    if (prio_conflict) begin
      if (wait_cnt_q == WAIT_LAST) begin
        state_d = FORCE;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
    cpu_rvalid_d = cpu_win & ~bus.cpu_we;
    dma_rvalid_d = dma_win & ~bus.dma_we;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PRIO;
      wait_cnt_q   <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign bus.cpu_stall  = bus.cpu_req & ~cpu_win;
  assign bus.dma_gnt    = dma_win;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.rdata      = bus.ram_q_a;

  always_comb begin
    bus.ram_address_a = 16'h0000;
    bus.ram_data_a    = 8'h00;
    bus.ram_wren_a    = 1'b0;
    if (cpu_win) begin
      bus.ram_address_a = bus.cpu_addr;
      bus.ram_data_a    = bus.cpu_wdata;
      bus.ram_wren_a    = bus.cpu_we;
    end else if (dma_win) begin
      bus.ram_address_a = bus.dma_addr;
      bus.ram_data_a    = bus.dma_wdata;
      bus.ram_wren_a    = bus.dma_we;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [15:0] cpu_cnt_q, dma_cnt_q, cfl_cnt_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_cnt_q <= 16'h0000;
      dma_cnt_q <= 16'h0000;
      cfl_cnt_q <= 16'h0000;
    end else begin
      if (cpu_win && cpu_cnt_q != 16'hFFFF) cpu_cnt_q <= cpu_cnt_q + 16'd1;
      if (dma_win && dma_cnt_q != 16'hFFFF) dma_cnt_q <= dma_cnt_q + 16'd1;
      if (prio_conflict && cfl_cnt_q != 16'hFFFF) cfl_cnt_q <= cfl_cnt_q + 16'd1;
    end
  end

  assign cpu_grant_count = cpu_cnt_q;
  assign dma_grant_count = dma_cnt_q;
  assign conflict_count  = cfl_cnt_q;
`else
  assign cpu_grant_count = 16'h0000;
  assign dma_grant_count = 16'h0000;
  assign conflict_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if bus();
  ram_port_arbiter_if bus1();
  logic [15:0] cpu_cnt, dma_cnt, cfl_cnt, cpu_cnt1, dma_cnt1, cfl_cnt1;
  logic [7:0]  mem [0:255];

  ram_port_arbiter #(.MAX_WAIT(4)) u_dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .cpu_grant_count(cpu_cnt), .dma_grant_count(dma_cnt), .conflict_count(cfl_cnt)
  );

  ram_port_arbiter #(.MAX_WAIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave),
    .cpu_grant_count(cpu_cnt1), .dma_grant_count(dma_cnt1), .conflict_count(cfl_cnt1)
  );

  // Synchronous-read RAM behind port a; preloaded while reset is low
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 8'hA5 : 8'h00;
    end else if (bus.ram_wren_a) begin
      mem[bus.ram_address_a[7:0]] <= bus.ram_data_a;
    end
    bus.ram_q_a <= mem[bus.ram_address_a[7:0]];
  end

  assign bus1.ram_q_a = 8'h00;

  task automatic set_cpu(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
    bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
    set_dma(1'b1, 1'b1, 16'h0020, 8'h3C);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL rst_stall got=%b exp=1", bus.cpu_stall); end
    checks++; if (bus.dma_gnt !== 1'b0) begin failures++; $display("FAIL rst_dma_gnt got=%b exp=0", bus.dma_gnt); end
    checks++; if (bus.ram_wren_a !== 1'b0) begin failures++; $display("FAIL rst_wren got=%b exp=0", bus.ram_wren_a); end
    checks++; if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b%b exp=00", bus.cpu_rvalid, bus.dma_rvalid); end
    set_cpu(1'b0, 1'b0, 16'h0010, 8'h00);
    #1;
    checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall_idle got=%b exp=0", bus.cpu_stall); end
    set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_read();
    set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
    @(negedge clk);
    checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL rd_stall got=%b exp=0", bus.cpu_stall); end
    checks++; if (bus.ram_address_a !== 16'h0010 || bus.ram_wren_a !== 1'b0) begin failures++; $display("FAIL rd_addr got=%h/%b exp=0010/0", bus.ram_address_a, bus.ram_wren_a); end
    next_cycle();
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.dma_rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid got=%b%b exp=10", bus.cpu_rvalid, bus.dma_rvalid); end
    checks++; if (bus.rdata !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h exp=a5", bus.rdata); end
    #1;
    checks++; if (bus.ram_address_a !== 16'h0 || bus.ram_data_a !== 8'h0 || bus.ram_wren_a !== 1'b0) begin failures++; $display("FAIL idle_ram got=%h/%h/%b exp=0/0/0", bus.ram_address_a, bus.ram_data_a, bus.ram_wren_a); end
    next_cycle();
    checks++; if (bus.cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b exp=0", bus.cpu_rvalid); end
  endtask

  task automatic test_dma_write();
    set_dma(1'b1, 1'b1, 16'h0020, 8'h3C);
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b1 || bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b/%b exp=1/0", bus.dma_gnt, bus.cpu_stall); end
    checks++; if (bus.ram_wren_a !== 1'b1 || bus.ram_address_a !== 16'h0020 || bus.ram_data_a !== 8'h3C) begin failures++; $display("FAIL wr_ram got=%b/%h/%h exp=1/0020/3c", bus.ram_wren_a, bus.ram_address_a, bus.ram_data_a); end
    next_cycle();
    set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
    set_cpu(1'b1, 1'b0, 16'h0020, 8'h00);
    checks++; if (bus.dma_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid got=%b%b exp=00", bus.cpu_rvalid, bus.dma_rvalid); end
    next_cycle();
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.rdata !== 8'h3C) begin failures++; $display("FAIL wr_readback got=%b/%h exp=1/3c", bus.cpu_rvalid, bus.rdata); end
  endtask

  task automatic test_back_to_back();
    set_dma(1'b1, 1'b0, 16'h0010, 8'h00);
    next_cycle();
    set_dma(1'b1, 1'b0, 16'h0020, 8'h00);
    checks++; if (bus.dma_rvalid !== 1'b1 || bus.cpu_rvalid !== 1'b0 || bus.rdata !== 8'hA5) begin failures++; $display("FAIL b2b_first got=%b%b/%h exp=01/a5", bus.cpu_rvalid, bus.dma_rvalid, bus.rdata); end
    next_cycle();
    set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
    checks++; if (bus.dma_rvalid !== 1'b1 || bus.rdata !== 8'h3C) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/3c", bus.dma_rvalid, bus.rdata); end
    next_cycle();
    checks++; if (bus.dma_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", bus.dma_rvalid); end
  endtask

  task automatic test_force_pattern();
    logic exp;
    set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
    set_dma(1'b1, 1'b1, 16'h0030, 8'h77);
    for (int k = 0; k < 10; k++) begin
      exp = ((k % 5) == 4);
      @(negedge clk);
      checks++; if (bus.dma_gnt !== exp || bus.cpu_stall !== exp) begin failures++; $display("FAIL force_c%0d gnt/stall got=%b/%b exp=%b", k, bus.dma_gnt, bus.cpu_stall, exp); end
      next_cycle();
      checks++; if (bus.cpu_rvalid !== !exp || bus.dma_rvalid !== 1'b0) begin failures++; $display("FAIL force_rv%0d got=%b%b exp=%b0", k, bus.cpu_rvalid, bus.dma_rvalid, !exp); end
    end
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
    next_cycle();
  endtask

  task automatic test_wait_restart();
    logic [7:0] dreq = 8'b1111_1011;
    logic [7:0] egnt = 8'b1000_0000;
    set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
    for (int k = 0; k < 8; k++) begin
      set_dma(dreq[k], 1'b1, 16'h0030, 8'h77);
      @(negedge clk);
      checks++; if (bus.dma_gnt !== egnt[k] || bus.cpu_stall !== egnt[k]) begin failures++; $display("FAIL restart_c%0d gnt/stall got=%b/%b exp=%b", k, bus.dma_gnt, bus.cpu_stall, egnt[k]); end
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
    next_cycle();
  endtask

  task automatic test_reset_drop();
    set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
    set_dma(1'b1, 1'b1, 16'h0030, 8'h77);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) begin
        checks++; if (bus.ram_address_a !== 16'h0010 || bus.dma_gnt !== 1'b0) begin failures++; $display("FAIL drop_grant got=%h/%b exp=0010/0", bus.ram_address_a, bus.dma_gnt); end
        #1 reset = 1'b0;
      end
      next_cycle();
    end
    checks++; if (bus.cpu_rvalid !== 1'b0) begin failures++; $display("FAIL drop_rvalid got=%b exp=0", bus.cpu_rvalid); end
    checks++; if (bus.cpu_stall !== 1'b1 || bus.dma_gnt !== 1'b0 || bus.ram_wren_a !== 1'b0) begin failures++; $display("FAIL drop_hold got=%b/%b/%b exp=1/0/0", bus.cpu_stall, bus.dma_gnt, bus.ram_wren_a); end
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
    set_dma(1'b1, 1'b1, 16'h0030, 8'h77);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (bus.dma_gnt !== (k == 4)) begin failures++; $display("FAIL drop_c%0d gnt got=%b exp=%b", k, bus.dma_gnt, (k == 4)); end
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
    next_cycle();
  endtask

  task automatic test_max_wait1();
    bus1.cpu_req = 1'b1; bus1.dma_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus1.dma_gnt !== k[0] || bus1.cpu_stall !== k[0]) begin failures++; $display("FAIL mw1_c%0d gnt/stall got=%b/%b exp=%b", k, bus1.dma_gnt, bus1.cpu_stall, k[0]); end
      next_cycle();
    end
    bus1.cpu_req = 1'b0; bus1.dma_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_stats();
    logic [15:0] e_cpu, e_dma, e_cfl;
`ifdef RAM_ARB_STATS_EN
    e_cpu = 16'd10; e_dma = 16'd2; e_cfl = 16'd8;
`else
    e_cpu = 16'd0; e_dma = 16'd0; e_cfl = 16'd0;
`endif
    @(negedge clk);
    reset = 1'b0;
    next_cycle();
    checks++; if (cpu_cnt !== 16'd0 || dma_cnt !== 16'd0 || cfl_cnt !== 16'd0) begin failures++; $display("FAIL stats_reset got=%0d/%0d/%0d exp=0/0/0", cpu_cnt, dma_cnt, cfl_cnt); end
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    set_cpu(1'b1, 1'b1, 16'h0040, 8'h11);
    set_dma(1'b1, 1'b1, 16'h0050, 8'h22);
    repeat (10) next_cycle();
    set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (2) next_cycle();
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    next_cycle();
    checks++; if (cpu_cnt !== e_cpu) begin failures++; $display("FAIL stats_cpu got=%0d exp=%0d", cpu_cnt, e_cpu); end
    checks++; if (dma_cnt !== e_dma) begin failures++; $display("FAIL stats_dma got=%0d exp=%0d", dma_cnt, e_dma); end
    checks++; if (cfl_cnt !== e_cfl) begin failures++; $display("FAIL stats_conflict got=%0d exp=%0d", cfl_cnt, e_cfl); end
  endtask

  initial begin
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0; bus1.cpu_wdata = 8'h0;
    bus1.dma_req = 1'b0; bus1.dma_we = 1'b0; bus1.dma_addr = 16'h0; bus1.dma_wdata = 8'h0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_back_to_back();
    test_force_pattern();
    test_wait_restart();
    test_reset_drop();
    test_max_wait1();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
